// File: rtl/imem_arbiter.sv
// Two-port arbiter/sequencer in front of the instruction-memory port.
// Define IMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module imem_arbiter #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ioReq0_valid,
  output logic                  ioReq0_ready,
  input  logic [ADDR_WIDTH-1:0] ioReq0_pc,
  output logic                  ioResp0_valid,
  output logic [INST_WIDTH-1:0] ioResp0_inst,
  input  logic                  ioReq1_valid,
  output logic                  ioReq1_ready,
  input  logic [ADDR_WIDTH-1:0] ioReq1_pc,
  output logic                  ioResp1_valid,
  output logic [INST_WIDTH-1:0] ioResp1_inst,
  output logic                  ioIMem_valid,
  input  logic                  ioIMem_ready,
  input  logic                  ioIMem_busy,
  output logic [ADDR_WIDTH-1:0] ioIMem_pc,
  input  logic [INST_WIDTH-1:0] ioIMem_inst
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MEM  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            stateReg, stateNext;
  logic [ADDR_WIDTH-1:0] pcReg, pcNext;
  logic                  portReg, portNext;
  logic [INST_WIDTH-1:0] instReg, instNext;
  logic                  grant0, grant1, memDone;

`ifdef IMEM_ARB_RR_EN
  // lastGrantReg holds the id of the most recently granted port.
  logic lastGrantReg, lastGrantNext;

  always_comb begin
    grant0 = ioReq0_valid && (!ioReq1_valid || lastGrantReg);
    grant1 = ioReq1_valid && (!ioReq0_valid || !lastGrantReg);
  end

  always_comb begin
    lastGrantNext = lastGrantReg;
    if (stateReg == IDLE && (grant0 || grant1))
      lastGrantNext = grant1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      lastGrantReg <= 1'b1;
    else
      lastGrantReg <= lastGrantNext;
  end
`else
  always_comb begin
    grant0 = ioReq0_valid;
    grant1 = ioReq1_valid && !ioReq0_valid;
  end
`endif

  // Busy masks ready: a stalled memory never completes.
  assign memDone = ioIMem_ready && !ioIMem_busy;

  always_comb begin
    stateNext = stateReg;
    pcNext    = pcReg;
    portNext  = portReg;
    instNext  = instReg;
    case (stateReg)
      IDLE: begin
        if (grant0 || grant1) begin
          stateNext = MEM;
          portNext  = grant1;
          pcNext    = grant1 ? ioReq1_pc : ioReq0_pc;
        end
      end
      MEM: begin
        if (memDone) begin
          stateNext = RESP;
          instNext  = ioIMem_inst;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg <= IDLE;
      pcReg    <= '0;
      portReg  <= 1'b0;
      instReg  <= '0;
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
      portReg  <= portNext;
      instReg  <= instNext;
    end
  end

  // Outputs are forced to their reset values while reset is high, so a
  // response caught by reset in RESP is never presented.
  always_comb begin
    ioReq0_ready  = !reset && stateReg == IDLE && grant0;
    ioReq1_ready  = !reset && stateReg == IDLE && grant1;
    ioIMem_valid  = !reset && stateReg == MEM;
    ioIMem_pc     = reset ? '0 : pcReg;
    ioResp0_valid = !reset && stateReg == RESP && !portReg;
    ioResp1_valid = !reset && stateReg == RESP && portReg;
    ioResp0_inst  = reset ? '0 : instReg;
    ioResp1_inst  = reset ? '0 : instReg;
  end

endmodule
